clkdiv_multi: RTL and testbench

//  - NCH-channel programmable tick/strobe generator; successor to the single-channel 8-bit divider.
//  - Each channel provides:
//      - a 1-cycle tick every (lim+1) clk cycles;
//      - a 50%-duty wave that toggles on each tick.
//  - Fully synchronous to clk: no derived clocks. Downstream logic (game timer, LED flash, tone
//    gen) uses tick as a clock enable.

---
 rtl/clkdiv_multi.sv | 72 +++++++
 tb/tb_clkdiv_multi.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/clkdiv_multi.sv
// Multi-channel tick/strobe generator with per-channel square-wave output.
// Optional CLKDIV_SHADOW_LIM_EN: limit is latched at period boundaries.
module clkdiv_multi #(
   parameter int NCH   = 2,
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       en,
   input  logic [NCH-1:0]       clr,
   input  logic [NCH*WIDTH-1:0] lim,
   output logic [NCH-1:0]       tick,
   output logic [NCH-1:0]       wave,
   output logic                 busy
);

   // run is low for the release edge, so counting starts one edge later
   logic run;

   always_ff @(posedge clk) begin
      if (!rst) run <= 1'b0;
      else      run <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst || !run) busy <= 1'b0;
      else              busy <= |en;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [WIDTH-1:0] cnt;
      logic [WIDTH-1:0] lim_in;
      logic [WIDTH-1:0] lim_eff;
      logic             wrap;

      assign lim_in = lim[i*WIDTH +: WIDTH];
      assign wrap   = cnt >= lim_eff;

`ifdef CLKDIV_SHADOW_LIM_EN
      always_ff @(posedge clk) begin
         if (!rst)
            lim_eff <= '0;
         else if (!run || clr[i] || (en[i] && wrap))
            lim_eff <= lim_in;
      end
`else
      assign lim_eff = lim_in;
`endif

      always_ff @(posedge clk) begin
         if (!rst || !run) begin
            cnt     <= '0;
            tick[i] <= 1'b0;
            wave[i] <= 1'b0;
         end else if (clr[i]) begin
            cnt     <= '0;
            tick[i] <= 1'b0;
            wave[i] <= 1'b0;
         end else if (!en[i]) begin
            tick[i] <= 1'b0;
         end else if (wrap) begin
            cnt     <= '0;
            tick[i] <= 1'b1;
            wave[i] <= ~wave[i];
         end else begin
            cnt     <= cnt + 1'b1;
            tick[i] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: directed reset/period checks
// followed by randomized traffic against a behavioural model.
module tb_clkdiv_multi;

   localparam int NCH   = 2;
   localparam int WIDTH = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH-1:0]       en;
   logic [NCH-1:0]       clr;
   logic [NCH*WIDTH-1:0] lim;
   logic [NCH-1:0]       tick;
   logic [NCH-1:0]       wave;
   logic                 busy;

   int checks   = 0;
   int failures = 0;

   // model state: count of enabled cycles since last wrap, latched limit
   int m_cnt  [NCH];
   int m_lim  [NCH];
   bit m_tick [NCH];
   bit m_wave [NCH];
   bit m_busy;
   bit m_live;

   clkdiv_multi #(.NCH(NCH), .WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (clr),
      .lim  (lim),
      .tick (tick),
      .wave (wave),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lim_of(input int ch);
      logic [NCH*WIDTH-1:0] v;
      v = lim;
      return int'(v[ch*WIDTH +: WIDTH]);
   endfunction

   // advance the model by one clock edge using the inputs present at that edge
   task automatic model_edge();
      int bound;
      if (!rst) begin
         m_live = 0;
         m_busy = 0;
         foreach (m_cnt[c]) begin
            m_cnt[c] = 0; m_tick[c] = 0; m_wave[c] = 0; m_lim[c] = 0;
         end
      end else if (!m_live) begin
         m_live = 1;
         m_busy = 0;
         foreach (m_cnt[c]) begin
            m_cnt[c] = 0; m_tick[c] = 0; m_wave[c] = 0;
            m_lim[c] = lim_of(c);
         end
      end else begin
         m_busy = (en != '0);
         foreach (m_cnt[c]) begin
`ifdef CLKDIV_SHADOW_LIM_EN
            bound = m_lim[c];
`else
            bound = lim_of(c);
`endif
            m_tick[c] = 0;
            if (clr[c]) begin
               m_cnt[c] = 0; m_wave[c] = 0;
               m_lim[c] = lim_of(c);
            end else if (en[c]) begin
               if (m_cnt[c] >= bound) begin
                  m_cnt[c]  = 0;
                  m_tick[c] = 1;
                  m_wave[c] = !m_wave[c];
                  m_lim[c]  = lim_of(c);
               end else begin
                  m_cnt[c] = m_cnt[c] + 1;
               end
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, "_busy"}, busy, m_busy);
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("%s_tick%0d", tag, c), tick[c], m_tick[c]);
         chk($sformatf("%s_wave%0d", tag, c), wave[c], m_wave[c]);
      end
   endtask

   initial begin
      bit w0;
      bit w1;
      rst = 1'b0;
      en  = '1;
      clr = '0;
      lim = {8'd5, 8'd5};

      // reset held for three edges with enables asserted
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst_tick", tick, 0);
         chk("rst_wave", wave, 0);
         chk("rst_busy", busy, 0);
      end

      // period check: lim0=3, lim1=0, cycle 0 follows the release edge
      @(negedge clk);
      rst = 1'b1;
      lim = {8'd0, 8'd3};
      w0  = 0;
      w1  = 0;
      for (int c = 0; c <= 13; c++) begin
         step();
         if (c >= 4 && c % 4 == 0) w0 = !w0;
         if (c >= 1) w1 = !w1;
         chk($sformatf("per_tick0_c%0d", c), tick[0], (c >= 4 && c % 4 == 0));
         chk($sformatf("per_tick1_c%0d", c), tick[1], (c >= 1));
         chk($sformatf("per_wave0_c%0d", c), wave[0], w0);
         chk($sformatf("per_wave1_c%0d", c), wave[1], w1);
         chk($sformatf("per_busy_c%0d", c), busy, (c >= 1));
      end

      // randomized traffic against the model
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 249) != 0);
         for (int c = 0; c < NCH; c++) begin
            en[c]  = ($urandom_range(0, 4) != 0);
            clr[c] = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) begin
               case ($urandom_range(0, 3))
                  0:       lim[c*WIDTH +: WIDTH] = 8'd255;
                  1:       lim[c*WIDTH +: WIDTH] = 8'd0;
                  default: lim[c*WIDTH +: WIDTH] = 8'($urandom_range(1, 12));
               endcase
            end
         end
         step();
         cmp_model("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
